wb_select_queue: RTL and testbench

- Parametrised, registered successor to the CPU's combinational register-file write-data selector.
- Each cycle it accepts one writeback request: a source select, a flattened bus of all candidate sources, and a destination register number.
- It latches the selected word and destination into a small in-order queue and presents them to the register file through a valid/ready handshake.
- It sits between the datapath source units (ALU, load/store, HI/LO, sign-extenders, shifters, exception vector) and the register file write port. Stalled register-file writes therefore back-pressure the control unit instead of losing data.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 55 +++++
 rtl/wb_select_queue.sv | 91 +++++++++
 tb/tb_wb_select_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared source indices, widths, FIFO state encoding and queue entry type
package wb_pkg;
   localparam int WB_SRC_ALU   = 0;
   localparam int WB_SRC_LS    = 1;
   localparam int WB_SRC_HI    = 2;
   localparam int WB_SRC_LO    = 3;
   localparam int WB_SRC_SE1   = 4;
   localparam int WB_SRC_SE16  = 5;
   localparam int WB_SRC_SHL16 = 6;
   localparam int WB_SRC_EXC   = 7;
   localparam int WB_SRC_SHIFT = 8;
   localparam int WB_NUM_SRC   = 9;
   localparam int WB_SEL_W     = 5;
   localparam int WB_REG_W     = 5;
   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t;
   typedef struct packed {
      logic [31:0]         data;
      logic [WB_REG_W-1:0] addr;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order DEPTH x W synchronous FIFO with registered full/empty state
module wb_fifo import wb_pkg::*; #(
   parameter int W = 37,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [W-1:0]       din,
   output logic [W-1:0]       dout,
   output logic [AW:0]        count,
   output logic               full,
   output logic               empty,
   output logic [AW-1:0]      rd_ptr,
   output logic [DEPTH*W-1:0] mem_flat
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count_nxt;
   logic          do_push, do_pop;
   fifo_state_t   state;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign full      = state == ST_FULL;
   assign empty     = state == ST_EMPTY;
   assign dout      = mem[rd_ptr];

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign mem_flat[k*W +: W] = mem[k];
   end

   // Storage, pointers, count and the occupancy state that drives full/empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= ST_EMPTY;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         state <= count_nxt == '0 ? ST_EMPTY :
                  count_nxt == (AW+1)'(DEPTH) ? ST_FULL : ST_PARTIAL;
      end
   end
endmodule

// File: rtl/wb_select_queue.sv
// wb_select_queue: registered writeback source selector feeding an in-order queue; WB_BYPASS_EN adds a forwarding search
module wb_select_queue import wb_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int NUM_SRC = WB_NUM_SRC,
   parameter int SEL_W = WB_SEL_W,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic [WB_REG_W-1:0]       in_dest,
   input  logic [NUM_SRC*DATA_W-1:0] src_bus,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [DATA_W-1:0]         wb_data,
   output logic [WB_REG_W-1:0]       wb_addr,
   output logic                      sel_err,
   input  logic [WB_REG_W-1:0]       fwd_addr,
   output logic                      fwd_hit,
   output logic [DATA_W-1:0]         fwd_data
);
   localparam int W  = DATA_W + WB_REG_W;
   localparam int AW = $clog2(DEPTH);

   logic               accept, push, pop, full, empty, sel_ok;
   logic [DATA_W-1:0]  sel_data;
   logic [W-1:0]       head;
   logic [AW:0]        count;
   logic [AW-1:0]      rd_ptr;
   logic [DEPTH*W-1:0] mem_flat;

   assign in_ready = !full;
   assign accept   = in_valid && in_ready;
   assign sel_ok   = 32'(in_sel) < NUM_SRC;
   assign push     = accept && in_dest != '0;
   assign wb_valid = !empty;
   assign pop      = wb_valid && wb_ready;
   assign wb_data  = wb_valid ? head[W-1 -: DATA_W] : '0;
   assign wb_addr  = wb_valid ? head[WB_REG_W-1:0] : '0;

   // Pick the requested source word; selects beyond the last source fall through to zero
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (in_sel == SEL_W'(i)) sel_data = src_bus[i*DATA_W +: DATA_W];
   end

   // Sticky record that an out-of-range select was ever accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sel_err <= 1'b0;
      else if (accept && !sel_ok) sel_err <= 1'b1;
   end

   wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .din     ({sel_data, in_dest}),
      .dout    (head),
      .count   (count),
      .full    (full),
      .empty   (empty),
      .rd_ptr  (rd_ptr),
      .mem_flat(mem_flat)
   );

`ifdef WB_BYPASS_EN
   // Walk queued entries oldest to youngest so the youngest match wins
   always_comb begin
      logic [AW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if ((AW+1)'(i) < count && fwd_addr != '0 && mem_flat[idx*W +: WB_REG_W] == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_flat[idx*W + WB_REG_W +: DATA_W];
         end
      end
   end
`else
   logic unused_bypass;
   assign fwd_hit       = 1'b0;
   assign fwd_data      = '0;
   assign unused_bypass = &{1'b0, fwd_addr, count, rd_ptr, mem_flat};
`endif
endmodule

// File: tb/tb_wb_select_queue.sv
// tb_wb_select_queue: scoreboard bench for wb_select_queue (bypass checks follow WB_BYPASS_EN)
module tb_wb_select_queue;
   import wb_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [4:0]   in_sel = '0;
   logic [4:0]   in_dest = '0;
   logic [287:0] src_bus = '0;
   logic         wb_valid;
   logic         wb_ready = 1'b0;
   logic [31:0]  wb_data;
   logic [4:0]   wb_addr;
   logic         sel_err;
   logic [4:0]   fwd_addr = '0;
   logic         fwd_hit;
   logic [31:0]  fwd_data;

   int        n_checks = 0;
   int        n_fail = 0;
   wb_entry_t sb[$];

   wb_select_queue dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_dest(in_dest), .src_bus(src_bus),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
      .sel_err(sel_err), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every handshake cycle pops one expected entry; idle output must read zero
   always @(negedge clk) begin
      if (!reset && wb_valid && wb_ready) begin
         if (sb.size() == 0) check("unexpected_delivery", {27'd0, wb_addr, wb_data}, 64'd0);
         else begin
            wb_entry_t e;
            e = sb.pop_front();
            check("wb_data", 64'(wb_data), 64'(e.data));
            check("wb_addr", 64'(wb_addr), 64'(e.addr));
         end
      end else if (!reset && !wb_valid) begin
         check("idle_zero", {27'd0, wb_addr, wb_data}, 64'd0);
      end
   end

   // Issue one request; expected entry is scored once the accepting edge has passed
   task automatic send(input logic [4:0] sel, input logic [4:0] dest, input logic [31:0] val);
      wb_entry_t e;
      int t;
      for (int i = 0; i < 9; i++)
         src_bus[i*32 +: 32] = (32'(sel) == i) ? val : 32'hA000_0000 + i;
      in_sel = sel;
      in_dest = dest;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      src_bus = {9{32'h5A5A_5A5A}};
      in_sel = 5'd3;
      if (dest != 0) begin
         e.data = (sel < 9) ? val : 32'd0;
         e.addr = dest;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int t;
      wb_ready = 1'b1;
      t = 0;
      while ((wb_valid || sb.size() != 0) && t < 50) begin
         t++;
         @(negedge clk);
      end
      check("drain_empty", {31'd0, wb_valid} + 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_out", {27'd0, wb_addr, wb_data}, 64'd0);
      check("rst_sel_err", 64'(sel_err), 64'd0);
      check("rst_fwd", {31'd0, fwd_hit, fwd_data}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single push from HI source, one-cycle latency
      check("pre_push_valid", 64'(wb_valid), 64'd0);
      send(5'(WB_SRC_HI), 5'd8, 32'hDEAD_BEEF);
      check("latency_valid", 64'(wb_valid), 64'd1);
      check("latency_data", 64'(wb_data), 64'hDEAD_BEEF);
      drain();

      // fill to DEPTH, hold fifth request, then drain in order
      wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(5'(WB_SRC_ALU), 5'(i), 32'(i));
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      fork
         send(5'(WB_SRC_LS), 5'd5, 32'd5);
         begin
            repeat (2) begin
               @(posedge clk);
               #2;
               check("held_in_ready", 64'(in_ready), 64'd0);
               check("stall_data", 64'(wb_data), 64'd1);
            end
            wb_ready = 1'b1;
            @(negedge clk);
            check("pop_cycle_blocked", 64'(in_ready), 64'd0);
            @(posedge clk);
            #2;
            check("slot_freed", 64'(in_ready), 64'd1);
         end
      join
      drain();

      // register 0 destination is accepted but dropped
      wb_ready = 1'b0;
      send(5'(WB_SRC_LO), 5'd0, 32'h0000_0055);
      check("r0_in_ready", 64'(in_ready), 64'd1);
      check("r0_wb_valid", 64'(wb_valid), 64'd0);

      // out-of-range select enqueues zero and sets sticky error
      send(5'd12, 5'd9, 32'h0000_0077);
      check("bad_sel_err", 64'(sel_err), 64'd1);
      send(5'(WB_SRC_SHIFT), 5'd10, 32'h0000_0099);
      drain();
      check("sel_err_sticky", 64'(sel_err), 64'd1);

      // streaming push and pop every cycle
      wb_ready = 1'b1;
      for (int i = 0; i < 100; i++)
         send(5'($urandom_range(0, 8)), 5'($urandom_range(1, 31)), $urandom);
      drain();

      // asynchronous reset with three entries queued
      wb_ready = 1'b0;
      send(5'(WB_SRC_ALU), 5'd11, 32'h0000_0AAA);
      send(5'(WB_SRC_EXC), 5'd12, 32'h0000_0BBB);
      send(5'(WB_SRC_SE16), 5'd13, 32'h0000_0CCC);
      check("pre_rst_valid", 64'(wb_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_valid", 64'(wb_valid), 64'd0);
      check("async_rst_out", {27'd0, wb_addr, wb_data}, 64'd0);
      check("async_rst_sel_err", 64'(sel_err), 64'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      wb_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_valid", 64'(wb_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // bypass search over queued entries
      wb_ready = 1'b0;
      send(5'(WB_SRC_ALU), 5'd5, 32'h11);
      send(5'(WB_SRC_ALU), 5'd6, 32'h22);
      send(5'(WB_SRC_ALU), 5'd5, 32'h33);
      fwd_addr = 5'd5;
      #1;
`ifdef WB_BYPASS_EN
      check("fwd_r5", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'h33});
      fwd_addr = 5'd6;
      #1;
      check("fwd_r6", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'h22});
`else
      check("fwd_off_r5", {31'd0, fwd_hit, fwd_data}, 64'd0);
      fwd_addr = 5'd6;
      #1;
      check("fwd_off_r6", {31'd0, fwd_hit, fwd_data}, 64'd0);
`endif
      fwd_addr = 5'd0;
      #1;
      check("fwd_r0", 64'(fwd_hit), 64'd0);
      fwd_addr = 5'd7;
      #1;
      check("fwd_miss", 64'(fwd_hit), 64'd0);
      @(posedge clk);
      #1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
